// File: rtl/onehot_decoder_seq.sv
// Handshaked 3-to-8 one-hot decoder with a configurable dead-time gap after each output.
// Define ONEHOT_DECODER_SEQ_ACCUM_EN to add the clr_mask_i/acc_mask_o accumulator.
module onehot_decoder_seq #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [2:0] in_idx_i,
    input  logic       in_en_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [7:0] out_onehot_o,
    output logic [2:0] out_idx_o,
    output logic       busy_o
`ifdef ONEHOT_DECODER_SEQ_ACCUM_EN
    ,
    input  logic       clr_mask_i,
    output logic [7:0] acc_mask_o
`endif
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrive = 2'd1,
        StGap   = 2'd2
    } state_e;

    // Counter counts down to zero, so load one less than the gap length.
    localparam logic [3:0] GapLoad = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
    localparam bit HasGap = (GAP_CYCLES != 0);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] onehot_q, onehot_d;
    logic [2:0] idx_q, idx_d;
    logic       accept, handshake;

    assign accept    = in_valid_i & (state_q == StIdle);
    assign handshake = out_ready_i & (state_q == StDrive);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            onehot_q <= 8'h00;
            idx_q    <= 3'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        onehot_d = onehot_q;
        idx_d    = idx_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    onehot_d = in_en_i ? (8'h01 << in_idx_i) : 8'h00;
                    idx_d    = in_idx_i;
                    state_d  = StDrive;
                end
            end
            StDrive: begin
                if (handshake) begin
                    onehot_d = 8'h00;
                    if (HasGap) begin
                        state_d = StGap;
                        cnt_d   = GapLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StGap: begin
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d  = StIdle;
                cnt_d    = 4'd0;
                onehot_d = 8'h00;
            end
        endcase
    end

    always_comb begin
        in_ready_o   = (state_q == StIdle);
        out_valid_o  = (state_q == StDrive);
        busy_o       = (state_q != StIdle);
        out_onehot_o = onehot_q;
        out_idx_o    = idx_q;
    end

`ifdef ONEHOT_DECODER_SEQ_ACCUM_EN
    logic [7:0] acc_q, acc_d;

    // A clear coinciding with a handshake keeps only the current decode.
    always_comb begin
        acc_d = acc_q;
        if (clr_mask_i) begin
            acc_d = handshake ? onehot_q : 8'h00;
        end else if (handshake) begin
            acc_d = acc_q | onehot_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= 8'h00;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_mask_o = acc_q;
`endif

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Self-checking bench: DUT a uses the default gap of 2, DUT b uses a zero gap.
// Directed scenarios plus a randomized run against a transaction-level model.
module tb_onehot_decoder_seq;

    localparam int unsigned GA = 2;

    logic       clk;
    logic       rst_n;
    int         checks;
    int         errors;

    logic       a_in_valid, a_in_ready, a_in_en, a_out_valid, a_out_ready, a_busy;
    logic [2:0] a_in_idx, a_out_idx;
    logic [7:0] a_out_onehot;
    logic       b_in_valid, b_in_ready, b_in_en, b_out_valid, b_out_ready, b_busy;
    logic [2:0] b_in_idx, b_out_idx;
    logic [7:0] b_out_onehot;
`ifdef ONEHOT_DECODER_SEQ_ACCUM_EN
    logic       a_clr_mask, b_clr_mask;
    logic [7:0] a_acc_mask, b_acc_mask;
`endif

    onehot_decoder_seq #(.GAP_CYCLES(GA)) u_dut_a (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (a_in_valid),
        .in_ready_o  (a_in_ready),
        .in_idx_i    (a_in_idx),
        .in_en_i     (a_in_en),
        .out_valid_o (a_out_valid),
        .out_ready_i (a_out_ready),
        .out_onehot_o(a_out_onehot),
        .out_idx_o   (a_out_idx),
        .busy_o      (a_busy)
`ifdef ONEHOT_DECODER_SEQ_ACCUM_EN
        ,
        .clr_mask_i  (a_clr_mask),
        .acc_mask_o  (a_acc_mask)
`endif
    );

    onehot_decoder_seq #(.GAP_CYCLES(0)) u_dut_b (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (b_in_valid),
        .in_ready_o  (b_in_ready),
        .in_idx_i    (b_in_idx),
        .in_en_i     (b_in_en),
        .out_valid_o (b_out_valid),
        .out_ready_i (b_out_ready),
        .out_onehot_o(b_out_onehot),
        .out_idx_o   (b_out_idx),
        .busy_o      (b_busy)
`ifdef ONEHOT_DECODER_SEQ_ACCUM_EN
        ,
        .clr_mask_i  (b_clr_mask),
        .acc_mask_o  (b_acc_mask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: one full transaction on DUT a with out_ready high, back to idle.
    task automatic txn_a(input logic [2:0] idx, input logic en);
        a_in_valid  = 1'b1;
        a_in_idx    = idx;
        a_in_en     = en;
        a_out_ready = 1'b1;
        step();
        a_in_valid = 1'b0;
        for (int i = 0; i < 1 + int'(GA); i++) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (a_out_valid !== 1'b0 || a_out_onehot !== 8'h00 || a_out_idx !== 3'd0
            || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b hot=%h idx=%0d busy=%b want 0 00 0 0",
                     a_out_valid, a_out_onehot, a_out_idx, a_busy);
        end
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got a_rdy=%b b_rdy=%b busy=%b want 1 1 0",
                     a_in_ready, b_in_ready, a_busy);
        end
    endtask

    task automatic test_basic();
        a_in_valid  = 1'b1;
        a_in_idx    = 3'd5;
        a_in_en     = 1'b1;
        a_out_ready = 1'b1;
        step();
        a_in_valid = 1'b0;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_onehot !== 8'h20 || a_out_idx !== 3'd5
            || a_in_ready !== 1'b0 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_drive: got v=%b hot=%h idx=%0d rdy=%b busy=%b want 1 20 5 0 1",
                     a_out_valid, a_out_onehot, a_out_idx, a_in_ready, a_busy);
        end
        for (int g = 0; g < int'(GA); g++) begin
            step();
            checks++;
            if (a_out_valid !== 1'b0 || a_out_onehot !== 8'h00 || a_in_ready !== 1'b0
                || a_out_idx !== 3'd5 || a_busy !== 1'b1) begin
                errors++;
                $display("FAIL basic_gap%0d: got v=%b hot=%h rdy=%b idx=%0d busy=%b want 0 00 0 5 1",
                         g, a_out_valid, a_out_onehot, a_in_ready, a_out_idx, a_busy);
            end
        end
        step();
        checks++;
        if (a_in_ready !== 1'b1 || a_busy !== 1'b0 || a_out_idx !== 3'd5) begin
            errors++;
            $display("FAIL basic_idle: got rdy=%b busy=%b idx=%0d want 1 0 5",
                     a_in_ready, a_busy, a_out_idx);
        end
    endtask

    task automatic test_backpressure();
        a_in_valid  = 1'b1;
        a_in_idx    = 3'd7;
        a_in_en     = 1'b1;
        a_out_ready = 1'b0;
        step();
        a_in_valid = 1'b1;
        a_in_idx   = 3'd1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (a_out_valid !== 1'b1 || a_out_onehot !== 8'h80 || a_out_idx !== 3'd7
                || a_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b hot=%h idx=%0d rdy=%b want 1 80 7 0",
                         i, a_out_valid, a_out_onehot, a_out_idx, a_in_ready);
            end
            step();
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        step();
        checks++;
        if (a_out_valid !== 1'b0 || a_out_onehot !== 8'h00 || a_out_idx !== 3'd7) begin
            errors++;
            $display("FAIL bp_release: got v=%b hot=%h idx=%0d want 0 00 7",
                     a_out_valid, a_out_onehot, a_out_idx);
        end
        for (int g = 0; g < int'(GA); g++) step();
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_idle: got rdy=%b want 1", a_in_ready);
        end
    endtask

    task automatic test_no_line();
        a_in_valid  = 1'b1;
        a_in_idx    = 3'd3;
        a_in_en     = 1'b0;
        a_out_ready = 1'b1;
        step();
        a_in_valid = 1'b0;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_onehot !== 8'h00 || a_out_idx !== 3'd3) begin
            errors++;
            $display("FAIL no_line: got v=%b hot=%h idx=%0d want 1 00 3",
                     a_out_valid, a_out_onehot, a_out_idx);
        end
        for (int g = 0; g < 1 + int'(GA); g++) step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] want;
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_en     = 1'b1;
        for (int k = 0; k < 8; k++) begin
            b_in_idx = 3'(k);
            want     = 8'(1 << k);
            step();
            b_in_idx = 3'(k + 3);
            checks++;
            if (b_out_valid !== 1'b1 || b_out_onehot !== want || b_out_idx !== 3'(k)
                || b_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_drive%0d: got v=%b hot=%h idx=%0d rdy=%b want 1 %h %0d 0",
                         k, b_out_valid, b_out_onehot, b_out_idx, b_in_ready, want, k);
            end
            step();
            checks++;
            if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_out_onehot !== 8'h00) begin
                errors++;
                $display("FAIL b2b_idle%0d: got v=%b rdy=%b hot=%h want 0 1 00",
                         k, b_out_valid, b_in_ready, b_out_onehot);
            end
        end
        b_in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        a_in_valid  = 1'b1;
        a_in_idx    = 3'd2;
        a_in_en     = 1'b1;
        a_out_ready = 1'b0;
        step();
        a_in_valid = 1'b0;
        checks++;
        if (a_out_onehot !== 8'h04 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: got hot=%h busy=%b want 04 1", a_out_onehot, a_busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_out_onehot !== 8'h00 || a_busy !== 1'b0
            || a_out_idx !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_async: got v=%b hot=%h busy=%b idx=%0d want 0 00 0 0",
                     a_out_valid, a_out_onehot, a_busy, a_out_idx);
        end
        @(negedge clk);
        rst_n       = 1'b1;
        a_in_valid  = 1'b1;
        a_in_idx    = 3'd6;
        a_out_ready = 1'b1;
        step();
        a_in_valid = 1'b0;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_onehot !== 8'h40 || a_out_idx !== 3'd6) begin
            errors++;
            $display("FAIL rstmid_accept: got v=%b hot=%h idx=%0d want 1 40 6",
                     a_out_valid, a_out_onehot, a_out_idx);
        end
        for (int g = 0; g < 1 + int'(GA); g++) step();
    endtask

`ifdef ONEHOT_DECODER_SEQ_ACCUM_EN
    task automatic test_accum();
        a_clr_mask = 1'b1;
        step();
        a_clr_mask = 1'b0;
        txn_a(3'd1, 1'b1);
        txn_a(3'd4, 1'b1);
        txn_a(3'd6, 1'b1);
        checks++;
        if (a_acc_mask !== 8'h52) begin
            errors++;
            $display("FAIL accum_or: got %h want 52", a_acc_mask);
        end
        a_in_valid  = 1'b1;
        a_in_idx    = 3'd0;
        a_in_en     = 1'b1;
        a_out_ready = 1'b1;
        step();
        a_in_valid = 1'b0;
        a_clr_mask = 1'b1;
        step();
        a_clr_mask = 1'b0;
        checks++;
        if (a_acc_mask !== 8'h01) begin
            errors++;
            $display("FAIL accum_clr_hs: got %h want 01", a_acc_mask);
        end
        for (int g = 0; g < int'(GA); g++) step();
    endtask
`endif

    // Transaction-level model: a held output word and a count of remaining dead cycles.
    task automatic test_random();
        bit         m_hold;
        int         m_gap;
        logic [7:0] m_hot;
        logic [2:0] m_idx;
        logic       exp_ready;
        logic [7:0] exp_hot;
`ifdef ONEHOT_DECODER_SEQ_ACCUM_EN
        logic [7:0] m_acc;
        a_clr_mask = 1'b1;
        step();
        a_clr_mask = 1'b0;
        m_acc = 8'h00;
`endif
        m_hold = 1'b0;
        m_gap  = 0;
        m_hot  = 8'h00;
        m_idx  = a_out_idx === 3'd0 ? 3'd0 : 3'd6;
        for (int c = 0; c < 400; c++) begin
            exp_ready = !m_hold && (m_gap == 0);
            exp_hot   = m_hold ? m_hot : 8'h00;
            checks++;
            if (a_in_ready !== exp_ready || a_out_valid !== m_hold || a_out_onehot !== exp_hot
                || a_out_idx !== m_idx || a_busy !== !exp_ready) begin
                errors++;
                $display("FAIL rand_c%0d: got rdy=%b v=%b hot=%h idx=%0d busy=%b want %b %b %h %0d %b",
                         c, a_in_ready, a_out_valid, a_out_onehot, a_out_idx, a_busy,
                         exp_ready, m_hold, exp_hot, m_idx, !exp_ready);
            end
`ifdef ONEHOT_DECODER_SEQ_ACCUM_EN
            checks++;
            if (a_acc_mask !== m_acc) begin
                errors++;
                $display("FAIL rand_acc_c%0d: got %h want %h", c, a_acc_mask, m_acc);
            end
            a_clr_mask = ($urandom_range(0, 15) == 0);
`endif
            a_in_valid  = $urandom_range(0, 1) == 1;
            a_in_idx    = 3'($urandom_range(0, 7));
            a_in_en     = $urandom_range(0, 3) != 0;
            a_out_ready = $urandom_range(0, 2) != 0;
`ifdef ONEHOT_DECODER_SEQ_ACCUM_EN
            if (a_clr_mask) m_acc = (m_hold && a_out_ready) ? m_hot : 8'h00;
            else if (m_hold && a_out_ready) m_acc = m_acc | m_hot;
`endif
            if (m_hold) begin
                if (a_out_ready) begin
                    m_hold = 1'b0;
                    m_gap  = int'(GA);
                end
            end else if (m_gap > 0) begin
                m_gap = m_gap - 1;
            end else if (a_in_valid) begin
                m_hold = 1'b1;
                m_hot  = a_in_en ? 8'(1 << a_in_idx) : 8'h00;
                m_idx  = a_in_idx;
            end
            step();
        end
        a_in_valid = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        a_in_valid  = 1'b0;
        a_in_idx    = 3'd0;
        a_in_en     = 1'b0;
        a_out_ready = 1'b0;
        b_in_valid  = 1'b0;
        b_in_idx    = 3'd0;
        b_in_en     = 1'b0;
        b_out_ready = 1'b0;
`ifdef ONEHOT_DECODER_SEQ_ACCUM_EN
        a_clr_mask  = 1'b0;
        b_clr_mask  = 1'b0;
`endif
        test_reset();
        test_basic();
        test_backpressure();
        test_no_line();
        test_back_to_back();
        test_reset_mid();
`ifdef ONEHOT_DECODER_SEQ_ACCUM_EN
        test_accum();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/onehot_decoder_seq.md
ONEHOT_DECODER_SEQ -- requirements
Module: onehot_decoder_seq

Interface
REQ-001 Parameter GAP_CYCLES, default 2, dead-time cycles inserted after each output handshake; legal range 0..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  index request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 in_idx  input  3  line index 0..7 to assert.
REQ-007 in_en  input  1  1 = decode in_idx; 0 = "no line" request.
REQ-008 out_valid  output  1  out_onehot/out_idx valid.
REQ-009 out_ready  input  1  consumer accepts output.
REQ-010 out_onehot  output  8  registered one-hot decode, bit in_idx set.
REQ-011 out_idx  output  3  registered copy of accepted in_idx.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states SHALL be IDLE, DRIVE, GAP; encoding is implementation choice.
REQ-014 in_ready SHALL be 1 only in IDLE; request accepted on edge where in_valid & in_ready.
REQ-015 On accept: out_onehot <= in_en ? (8'h01 << in_idx) : 8'h00; out_idx <= in_idx; state -> DRIVE; out_valid high from next cycle (latency 1).
REQ-016 In DRIVE, out_valid, out_onehot, out_idx SHALL stay stable until out_valid & out_ready.
REQ-017 On output handshake: out_valid <= 0, out_onehot <= 8'h00; state -> GAP with counter loaded to GAP_CYCLES-1 if GAP_CYCLES>0, else state -> IDLE.
REQ-018 GAP SHALL last exactly GAP_CYCLES cycles with out_valid=0, out_onehot=0, in_ready=0, then -> IDLE.
REQ-019 Consequence: with GAP_CYCLES=G, minimum accept-to-accept spacing is 2+G cycles when out_ready held high.
REQ-020 out_onehot SHALL never have more than one bit set; in_en=0 yields out_valid=1 with out_onehot=8'h00.
REQ-021 in_valid/in_idx changes while in_ready=0 SHALL be ignored; out_ready while out_valid=0 SHALL be ignored.
REQ-022 out_idx SHALL retain last accepted value outside DRIVE.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, out_valid=0, out_onehot=8'h00, out_idx=3'd0, busy=0, in_ready=1 (after release), gap counter 0, acc_mask=8'h00 if present.
REQ-024 Reset mid-DRIVE or mid-GAP SHALL abort the transaction with no output handshake; first accept possible on first edge after rst_n rises.

Configuration
REQ-025 Macro ONEHOT_DECODER_SEQ_ACCUM_EN: when defined, ports clr_mask (input 1) and acc_mask (output 8) exist.
REQ-026 With macro: on each output handshake acc_mask <= acc_mask | out_onehot; clr_mask high clears acc_mask next edge; simultaneous clr_mask and handshake -> acc_mask = out_onehot.
REQ-027 Without macro: ports clr_mask/acc_mask and accumulator logic absent; all other behaviour identical.

Verification
REQ-028 Reset then in_valid=1, in_idx=5, in_en=1, out_ready=1, GAP_CYCLES=2 -> next cycle out_valid=1, out_onehot=8'h20, out_idx=5; then 2 cycles out_onehot=0, in_ready=0; in_ready=1 on 4th cycle after accept.
REQ-029 Backpressure: accept idx=7, out_ready=0 for 5 cycles -> out_onehot=8'h80 stable 5 cycles, in_ready=0; out_ready=1 -> handshake, out_valid drops next cycle.
REQ-030 in_en=0, in_idx=3 -> out_valid=1, out_onehot=8'h00, out_idx=3.
REQ-031 GAP_CYCLES=0, out_ready=1, back-to-back idx 0..7 -> one accept every 2 cycles, out_onehot 8'h01..8'h80 in order.
REQ-032 Assert rst_n=0 mid-DRIVE (idx=2) -> out_valid=0, out_onehot=8'h00 immediately, busy=0; new request accepted after release.
REQ-033 With ONEHOT_DECODER_SEQ_ACCUM_EN: idx 1,4,6 handshakes -> acc_mask=8'h52; clr_mask on idx=0 handshake edge -> acc_mask=8'h01.
